// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: frame FSM, LSB-first shifter, parity generator and line driver, one bit per CLK.
// Optional break generator (Break_Req input, BREAK state) is built when UART_TX_BREAK_EN is defined.
module uart_tx_frame_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic                  Stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                  Break_Req,
`endif
  output logic                  Ready,
  output logic                  Busy,
  output logic                  TX_OUT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd6;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [2:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  stop2_reg, stop2_next;
  logic                  break_req;
  logic                  accept;

`ifdef UART_TX_BREAK_EN
  assign break_req = Break_Req;
`else
  assign break_req = 1'b0;
`endif

  // A pending break blocks new words while idle.
  always_comb begin
    case (state_reg)
      S_IDLE:  Ready = !break_req;
      S_STOP1: Ready = !stop2_reg;
      S_STOP2: Ready = 1'b1;
      default: Ready = 1'b0;
    endcase
  end

  assign accept = Data_Valid & Ready;
  assign Busy   = (state_reg != S_IDLE);

  always_comb begin
    case (state_reg)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = shift_reg[0];
      S_PARITY: TX_OUT = par_bit_reg;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  TX_OUT = 1'b0;
`endif
      default:  TX_OUT = 1'b1;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    stop2_next   = stop2_reg;

    case (state_reg)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req)
          state_next = S_BREAK;
        else
`endif
        if (accept)
          state_next = S_START;
      end
      S_START: begin
        cnt_next   = '0;
        state_next = S_DATA;
      end
      S_DATA: begin
        shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST)
          state_next = par_en_reg ? S_PARITY : S_STOP1;
      end
      S_PARITY: state_next = S_STOP1;
      S_STOP1: begin
        if (stop2_reg)
          state_next = S_STOP2;
        else
          state_next = accept ? S_START : S_IDLE;
      end
      S_STOP2: state_next = accept ? S_START : S_IDLE;
`ifdef UART_TX_BREAK_EN
      // Release from break emits a single mark bit before the line is reusable.
      S_BREAK: begin
        if (!break_req) begin
          state_next = S_STOP1;
          stop2_next = 1'b0;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    // Config is sampled only on accept; parity is resolved here so the shifter never needs it.
    if (accept) begin
      shift_next   = P_Data;
      par_en_next  = Par_En;
      par_bit_next = (^P_Data) ^ Par_Typ;
      stop2_next   = Stop2;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      stop2_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      stop2_reg   <= stop2_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Scoreboard bench for uart_tx_frame_engine: expected line bits queued at accept, popped per CLK.
// Break scenario is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       dv = 1'b0, par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [7:0] pdata = '0;
  logic       ready, busy, tx;
  logic       dv5 = 1'b0, pe5 = 1'b0, pt5 = 1'b0, s25 = 1'b0;
  logic [4:0] pdata5 = '0;
  logic       ready5, busy5, tx5;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0, brk5 = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_frame_engine #(.DATA_WIDTH(8)) u_dut (
    .CLK(CLK), .RST(RST), .Data_Valid(dv), .P_Data(pdata),
    .Par_En(par_en), .Par_Typ(par_typ), .Stop2(stop2),
`ifdef UART_TX_BREAK_EN
    .Break_Req(brk),
`endif
    .Ready(ready), .Busy(busy), .TX_OUT(tx)
  );

  uart_tx_frame_engine #(.DATA_WIDTH(5)) u_dut5 (
    .CLK(CLK), .RST(RST), .Data_Valid(dv5), .P_Data(pdata5),
    .Par_En(pe5), .Par_Typ(pt5), .Stop2(s25),
`ifdef UART_TX_BREAK_EN
    .Break_Req(brk5),
`endif
    .Ready(ready5), .Busy(busy5), .TX_OUT(tx5)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference frame: start, LSB-first data, parity from a ones count, stop bit(s).
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back(((ones % 2) == 1) ^ pt);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    pdata = d; par_en = pe; par_typ = pt; stop2 = s2; dv = 1'b1;
    push_frame(d, pe, pt, s2);
    tick();
    dv = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_cmp++; if (tx5 !== 1'b1) begin n_bad++; $display("FAIL reset_tx5 got=%b exp=1", tx5); end
    RST = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_frame_even();
    logic seq [0:10];
    logic e;
    int   c = 0;
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pdata = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(seq[i]);
    tick();
    dv = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL even_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL even_busy cyc=%0d got=%b exp=1", c, busy); end
      c++;
      tick();
    end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL even_idle_tx got=%b exp=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL even_idle_busy got=%b exp=0", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL even_idle_ready got=%b exp=1", ready); end
    $display("txn even_parity data=a5 bits=%0d", c);
  endtask

  task automatic test_odd_stop2();
    logic e;
    int   c = 0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL odd_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL odd_busy cyc=%0d got=%b exp=1", c, busy); end
      c++;
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL odd_idle_busy got=%b exp=0", busy); end
    $display("txn odd_parity data=a5 bits=%0d", c);
    c = 0;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL stop2_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stop2_busy cyc=%0d got=%b exp=1", c, busy); end
      n_cmp++; if (ready !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL stop2_ready cyc=%0d got=%b", c, ready); end
      c++;
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop2_idle_busy got=%b exp=0", busy); end
    $display("txn two_stop data=00 bits=%0d", c);
  endtask

  task automatic test_back_to_back();
    logic e;
    int   c = 0;
    int   frames = 1;
    pdata = 8'h55; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    pdata = 8'hAA;
    while (exp_q.size() > 0 && c < 60) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", c, busy); end
      n_cmp++; if (ready !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL b2b_ready cyc=%0d got=%b", c, ready); end
      if (exp_q.size() == 0 && frames == 1) begin
        push_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        frames = 2;
      end else if (exp_q.size() == 0) begin
        dv = 1'b0;
      end
      c++;
      tick();
    end
    dv = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_tx got=%b exp=1", tx); end
    $display("txn back_to_back data=55,aa bits=%0d", c);
  endtask

  task automatic test_midframe_ignore();
    logic e;
    int   c = 0;
    send_frame(8'h3D, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL mid_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (ready !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL mid_ready cyc=%0d got=%b", c, ready); end
      if (c == 3) begin
        pdata = 8'hFF; par_en = 1'b0; par_typ = 1'b1; stop2 = 1'b1; dv = 1'b1;
      end else begin
        dv = 1'b0;
      end
      c++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_after_tx cyc=%0d got=%b exp=1", i, tx); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_after_busy cyc=%0d got=%b exp=0", i, busy); end
      tick();
    end
    $display("txn midframe_ignore data=3d bits=%0d", c);
  endtask

  task automatic test_reset_midframe();
    logic e;
    int   c = 0;
    send_frame(8'h96, 1'b0, 1'b0, 1'b0);
    while (c < 5) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL rstmid_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      c++;
      if (c < 5) tick();
    end
    RST = 1'b0;
    tick();
    RST = 1'b1;
    exp_q.delete();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx_after got=%b exp=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    c = 0;
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL rstmid_new_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_new_busy cyc=%0d got=%b exp=1", c, busy); end
      c++;
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_new_idle got=%b exp=0", busy); end
    $display("txn reset_midframe data=c3 bits=%0d", c);
  endtask

  task automatic test_width5();
    logic seq [0:7];
    int   c = 0;
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    pdata5 = 5'h15; pe5 = 1'b1; pt5 = 1'b0; s25 = 1'b0; dv5 = 1'b1;
    tick();
    dv5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (tx5 !== seq[i]) begin n_bad++; $display("FAIL w5_tx cyc=%0d got=%b exp=%b", i, tx5, seq[i]); end
      n_cmp++; if (busy5 !== 1'b1) begin n_bad++; $display("FAIL w5_busy cyc=%0d got=%b exp=1", i, busy5); end
      c++;
      tick();
    end
    n_cmp++; if (busy5 !== 1'b0) begin n_bad++; $display("FAIL w5_idle_busy got=%b exp=0", busy5); end
    n_cmp++; if (tx5 !== 1'b1) begin n_bad++; $display("FAIL w5_idle_tx got=%b exp=1", tx5); end
    $display("txn width5 data=15 bits=%0d", c);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic e;
    int   c = 0;
    pdata = 8'h5A; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1; dv = 1'b1; brk = 1'b1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL brk_ready_idle got=%b exp=0", ready); end
    tick();
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL brk_tx cyc=%0d got=%b exp=0", i, tx); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL brk_busy cyc=%0d got=%b exp=1", i, busy); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL brk_ready cyc=%0d got=%b exp=0", i, ready); end
      if (i == 19) brk = 1'b0;
      tick();
    end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL brk_mark_tx got=%b exp=1", tx); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL brk_mark_ready got=%b exp=1", ready); end
    push_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    tick();
    dv = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL brk_frame_tx cyc=%0d got=%b exp=%b", c, tx, e); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL brk_frame_busy cyc=%0d got=%b exp=1", c, busy); end
      c++;
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL brk_idle_busy got=%b exp=0", busy); end
    $display("txn break then data=5a bits=%0d", c);
  endtask
`endif

  initial begin
    test_reset();
    test_frame_even();
    test_odd_stop2();
    test_back_to_back();
    test_midframe_ignore();
    test_reset_midframe();
    test_width5();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
